// File: rtl/dff_mem_arbiter.sv
// rtl/dff_mem_arbiter.sv - two-port round-robin arbiter/sequencer for the 16-byte DFF RAM (optional write protect: DFF_MEM_ARB_WPROT_EN)
module dff_mem_arbiter #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int WPROT_BASE = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req_valid,
   input  logic              p0_req_we,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_req_ready,
   output logic              p0_rsp_valid,
   input  logic              p1_req_valid,
   input  logic              p1_req_we,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_req_ready,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rin,
   output logic              mem_rout_n,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state;
   logic              last_grant;
   logic              owner;
   logic              lat_we;
   logic              lat_prot;
   logic              grant_p0;
   logic              grant_p1;
   logic              sel_we;
   logic              sel_prot;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Winner selection: only in IDLE; on contention the port that did not win last time goes first
   always_comb begin
      grant_p0 = 1'b0;
      grant_p1 = 1'b0;
      if (state == IDLE) begin
         if (p0_req_valid && p1_req_valid) begin
            if (last_grant) grant_p0 = 1'b1;
            else            grant_p1 = 1'b1;
         end else if (p0_req_valid) begin
            grant_p0 = 1'b1;
         end else if (p1_req_valid) begin
            grant_p1 = 1'b1;
         end
      end
   end

   assign p0_req_ready = grant_p0;
   assign p1_req_ready = grant_p1;

   // Payload of the winning port, sampled only on the accept edge
   assign sel_we    = grant_p1 ? p1_req_we    : p0_req_we;
   assign sel_addr  = grant_p1 ? p1_req_addr  : p0_req_addr;
   assign sel_wdata = grant_p1 ? p1_req_wdata : p0_req_wdata;

`ifdef DFF_MEM_ARB_WPROT_EN
   localparam logic [ADDR_W-1:0] WPROT_ADDR = ADDR_W'(WPROT_BASE);
   assign sel_prot = sel_we && (sel_addr >= WPROT_ADDR);
`else
   assign sel_prot = 1'b0;
`endif

   // Sequencer: accept -> ISSUE -> (RDWAIT for reads) -> RESP; all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         owner        <= 1'b0;
         lat_we       <= 1'b0;
         lat_prot     <= 1'b0;
         busy         <= 1'b0;
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_rdata    <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_rin      <= 1'b0;
         mem_rout_n   <= 1'b1;
      end else begin
         // Command pins and response pulses default to idle so each lasts exactly one cycle
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
         rsp_err      <= 1'b0;
         mem_rin      <= 1'b0;
         mem_rout_n   <= 1'b1;
         case (state)
            IDLE: begin
               if (grant_p0 || grant_p1) begin
                  owner      <= grant_p1;
                  last_grant <= grant_p1;
                  lat_we     <= sel_we;
                  lat_prot   <= sel_prot;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  busy       <= 1'b1;
                  state      <= ISSUE;
                  if (sel_we) begin
                     if (!sel_prot) mem_rout_n <= 1'b0;
                  end else begin
                     mem_rin <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (lat_we) begin
                  p0_rsp_valid <= ~owner;
                  p1_rsp_valid <= owner;
                  rsp_err      <= lat_prot;
                  state        <= RESP;
               end else begin
                  state <= RDWAIT;
               end
            end
            RDWAIT: begin
               rsp_rdata    <= mem_rdata;
               p0_rsp_valid <= ~owner;
               p1_rsp_valid <= owner;
               state        <= RESP;
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// tb/tb_dff_mem_arbiter.sv - directed self-checking bench for dff_mem_arbiter
module tb_dff_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       p0_req_valid = 1'b0, p0_req_we = 1'b0;
   logic [3:0] p0_req_addr = '0;
   logic [7:0] p0_req_wdata = '0;
   logic       p0_req_ready, p0_rsp_valid;
   logic       p1_req_valid = 1'b0, p1_req_we = 1'b0;
   logic [3:0] p1_req_addr = '0;
   logic [7:0] p1_req_wdata = '0;
   logic       p1_req_ready, p1_rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err, busy;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_rin, mem_rout_n;
   logic [7:0] mem_rdata = '0;

   int total = 0;
   int bad = 0;

   logic [7:0] ram [16] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7,
                            8'hC8, 8'hC9, 8'hCA, 8'hCB, 8'hCC, 8'hCD, 8'hCE, 8'hCF};

   dff_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .WPROT_BASE(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
      .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready), .p0_rsp_valid(p0_rsp_valid),
      .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
      .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready), .p1_rsp_valid(p1_rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rin(mem_rin), .mem_rout_n(mem_rout_n),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural DFF RAM: registered read, synchronous write
   always @(posedge clk) begin
      if (mem_rin && mem_rout_n) mem_rdata <= ram[mem_addr];
      if (!mem_rin && !mem_rout_n) ram[mem_addr] <= mem_wdata;
   end

   task automatic clear_inputs();
      p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0;
      p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      #1;
      total++;
      if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, rsp_err, busy, rsp_rdata,
           mem_addr, mem_wdata, mem_rin, mem_rout_n} !== {6'b0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1})
         begin bad++; $display("FAIL reset_vals: got busy=%b rdata=%h addr=%h wdata=%h rin=%b rout_n=%b want 0/00/0/00/0/1",
                              busy, rsp_rdata, mem_addr, mem_wdata, mem_rin, mem_rout_n); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 4'd3; p0_req_wdata = 8'hA5;
      #1;
      total++;
      if ({p0_req_ready, p1_req_ready} !== 2'b10)
         begin bad++; $display("FAIL wr_accept: got rdy=%b%b want 10", p0_req_ready, p1_req_ready); end
      @(negedge clk);
      clear_inputs();
      total++;
      if ({mem_rin, mem_rout_n, mem_addr, mem_wdata, busy} !== {1'b0, 1'b0, 4'd3, 8'hA5, 1'b1})
         begin bad++; $display("FAIL wr_issue: got rin=%b rout_n=%b addr=%h wdata=%h busy=%b want 0 0 3 a5 1",
                              mem_rin, mem_rout_n, mem_addr, mem_wdata, busy); end
      @(negedge clk);
      total++;
      if ({p0_rsp_valid, p1_rsp_valid, rsp_err, rsp_rdata, mem_rin, mem_rout_n} !== {3'b100, 8'h00, 2'b01})
         begin bad++; $display("FAIL wr_resp: got v=%b%b err=%b rdata=%h rin=%b rout_n=%b want 10 0 00 0 1",
                              p0_rsp_valid, p1_rsp_valid, rsp_err, rsp_rdata, mem_rin, mem_rout_n); end
      @(negedge clk);
      total++;
      if ({busy, p0_rsp_valid} !== 2'b00)
         begin bad++; $display("FAIL wr_idle: got busy=%b v=%b want 0 0", busy, p0_rsp_valid); end
   endtask

   task automatic test_read();
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 4'd3;
      #1;
      total++;
      if ({p0_req_ready, p1_req_ready} !== 2'b01)
         begin bad++; $display("FAIL rd_accept: got rdy=%b%b want 01", p0_req_ready, p1_req_ready); end
      @(negedge clk);
      clear_inputs();
      total++;
      if ({mem_rin, mem_rout_n, mem_addr} !== {2'b11, 4'd3})
         begin bad++; $display("FAIL rd_issue: got rin=%b rout_n=%b addr=%h want 1 1 3", mem_rin, mem_rout_n, mem_addr); end
      @(negedge clk);
      total++;
      if ({mem_rin, mem_rout_n, p1_rsp_valid, busy} !== 4'b0101)
         begin bad++; $display("FAIL rd_wait: got rin=%b rout_n=%b v=%b busy=%b want 0 1 0 1",
                              mem_rin, mem_rout_n, p1_rsp_valid, busy); end
      @(negedge clk);
      total++;
      if ({p0_rsp_valid, p1_rsp_valid, rsp_err, rsp_rdata} !== {3'b010, 8'hA5})
         begin bad++; $display("FAIL rd_resp: got v=%b%b err=%b rdata=%h want 01 0 a5",
                              p0_rsp_valid, p1_rsp_valid, rsp_err, rsp_rdata); end
      @(negedge clk);
   endtask

   task automatic test_alternate();
      int g = 0;
      int p0i = 0;
      int p1i = 0;
      int r1 = 0;
      int cyc = 0;
      test_reset();
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 4'd0; p0_req_wdata = 8'h11;
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 4'd0;
      while (r1 < 4 && cyc < 60) begin
         #1;
         if (p0_req_ready && p1_req_ready)
            begin total++; bad++; $display("FAIL alt_dual_ready: got both ready at cycle %0d want one", cyc); end
         if (p0_req_ready) begin
            total++;
            if ((g % 2) !== 0) begin bad++; $display("FAIL alt_order: got p0 at grant %0d want p1", g); end
            g++; p0i++;
         end else if (p1_req_ready) begin
            total++;
            if ((g % 2) !== 1) begin bad++; $display("FAIL alt_order: got p1 at grant %0d want p0", g); end
            g++; p1i++;
         end
         @(negedge clk);
         cyc++;
         if (p0i < 4) begin p0_req_addr = 4'(p0i); p0_req_wdata = 8'(8'h11 + p0i); end
         else p0_req_valid = 1'b0;
         if (p1i < 4) p1_req_addr = 4'(p1i);
         else p1_req_valid = 1'b0;
         if (p1_rsp_valid) begin
            total++;
            if (rsp_rdata !== 8'(8'h11 + r1))
               begin bad++; $display("FAIL alt_rdata: got %h want %h (addr %0d)", rsp_rdata, 8'(8'h11 + r1), r1); end
            r1++;
         end
      end
      clear_inputs();
      total++;
      if (g !== 8 || r1 !== 4)
         begin bad++; $display("FAIL alt_count: got grants=%0d reads=%0d want 8 4", g, r1); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 4'd0;
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, p0_rsp_valid, rsp_rdata, mem_addr, mem_rin, mem_rout_n} !== {2'b00, 8'h00, 4'h0, 2'b01})
         begin bad++; $display("FAIL rst_mid_vals: got busy=%b v=%b rdata=%h addr=%h rin=%b rout_n=%b want 0 0 00 0 0 1",
                              busy, p0_rsp_valid, rsp_rdata, mem_addr, mem_rin, mem_rout_n); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (p0_rsp_valid || p1_rsp_valid || mem_rin || !mem_rout_n) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", seen); end
      p0_req_valid = 1'b1; p0_req_addr = 4'd1;
      p1_req_valid = 1'b1; p1_req_addr = 4'd1;
      #1;
      total++;
      if ({p0_req_ready, p1_req_ready} !== 2'b10)
         begin bad++; $display("FAIL rst_mid_grant: got rdy=%b%b want 10", p0_req_ready, p1_req_ready); end
      @(negedge clk);
      clear_inputs();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_drop();
      int seen = 0;
      p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 4'd5; p1_req_wdata = 8'h77;
      #1;
      total++;
      if (p1_req_ready !== 1'b1) begin bad++; $display("FAIL drop_p1_accept: got %b want 1", p1_req_ready); end
      @(negedge clk);
      clear_inputs();
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 4'd2;
      #1;
      total++;
      if (p0_req_ready !== 1'b0) begin bad++; $display("FAIL drop_busy_ready: got %b want 0", p0_req_ready); end
      @(negedge clk);
      clear_inputs();
      total++;
      if ({p1_rsp_valid, p0_rsp_valid} !== 2'b10)
         begin bad++; $display("FAIL drop_p1_resp: got v1=%b v0=%b want 1 0", p1_rsp_valid, p0_rsp_valid); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (p0_req_ready || p0_rsp_valid || mem_rin || !mem_rout_n) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL drop_quiet: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int nr = 0;
      p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 4'd5;
      for (int c = 0; c < 12; c++) begin
         if (p1_rsp_valid) begin
            total++;
            if (rsp_rdata !== 8'h77) begin bad++; $display("FAIL b2b_rdata: got %h want 77", rsp_rdata); end
            nr++;
         end
         if (n == 3) p1_req_valid = 1'b0;
         #1;
         if (p1_req_ready) begin
            total++;
            if (c !== 4 * n) begin bad++; $display("FAIL b2b_spacing: got accept at %0d want %0d", c, 4 * n); end
            n++;
         end
         @(negedge clk);
      end
      clear_inputs();
      total++;
      if (n !== 3 || nr !== 3) begin bad++; $display("FAIL b2b_count: got acc=%0d rsp=%0d want 3 3", n, nr); end
   endtask

   task automatic test_wprot();
      logic       exp_wcmd;
      logic       exp_err;
      logic [7:0] exp_rd;
`ifdef DFF_MEM_ARB_WPROT_EN
      exp_wcmd = 1'b0; exp_err = 1'b1; exp_rd = 8'hCD;
`else
      exp_wcmd = 1'b1; exp_err = 1'b0; exp_rd = 8'h5A;
`endif
      p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 4'd13; p0_req_wdata = 8'h5A;
      #1;
      total++;
      if (p0_req_ready !== 1'b1) begin bad++; $display("FAIL wp_accept: got %b want 1", p0_req_ready); end
      @(negedge clk);
      clear_inputs();
      total++;
      if ((!mem_rin && !mem_rout_n) !== exp_wcmd)
         begin bad++; $display("FAIL wp_issue: got wcmd=%b want %b", (!mem_rin && !mem_rout_n), exp_wcmd); end
      @(negedge clk);
      total++;
      if ({p0_rsp_valid, rsp_err} !== {1'b1, exp_err})
         begin bad++; $display("FAIL wp_resp: got v=%b err=%b want 1 %b", p0_rsp_valid, rsp_err, exp_err); end
      @(negedge clk);
      p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 4'd13;
      @(negedge clk);
      clear_inputs();
      repeat (2) @(negedge clk);
      total++;
      if ({p0_rsp_valid, rsp_err, rsp_rdata} !== {2'b10, exp_rd})
         begin bad++; $display("FAIL wp_read: got v=%b err=%b rdata=%h want 1 0 %h", p0_rsp_valid, rsp_err, rsp_rdata, exp_rd); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_alternate();
      test_reset_mid();
      test_drop();
      test_back_to_back();
      test_wprot();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
